// File: rtl/sd_card_responder_if.sv
// Host-side view of the SD card responder: CMD response request/stream and DAT block stream.
interface sd_card_responder_if #(
  parameter int DATA_WIDTH = 4,
  parameter int BLK_CNT_W  = 16
);
  logic                  resp_start;
  logic                  resp_long;
  logic [135:0]          resp_data;
  logic                  cmd_to_host;
  logic                  resp_busy;
  logic                  resp_done;
  logic                  data_start;
  logic [BLK_CNT_W-1:0]  blk_cnt;
  logic [7:0]            pattern_seed;
  logic                  pattern_inc;
  logic                  data_abort;
  logic [DATA_WIDTH-1:0] dat_to_host;
  logic                  data_busy;
  logic                  data_done;
  logic [BLK_CNT_W-1:0]  blocks_sent;

  modport master (
    output resp_start, resp_long, resp_data, data_start, blk_cnt, pattern_seed, pattern_inc, data_abort,
    input  cmd_to_host, resp_busy, resp_done, dat_to_host, data_busy, data_done, blocks_sent
  );
  modport slave (
    input  resp_start, resp_long, resp_data, data_start, blk_cnt, pattern_seed, pattern_inc, data_abort,
    output cmd_to_host, resp_busy, resp_done, dat_to_host, data_busy, data_done, blocks_sent
  );
endinterface

// File: rtl/sd_card_responder.sv
// SD card-side responder: serial CMD response shifter and framed DAT block
// generator with per-line CRC16, both in the card clock domain.
module sd_crc16_lane (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic upd,
  input  logic shift,
  input  logic din,
  output logic dout
);
  logic [15:0] crc;

  always_ff @(posedge clk) begin
    if (rst || clr)  crc <= '0;
    else if (upd)    crc <= {crc[14:0], 1'b0} ^ ({16{din ^ crc[15]}} & 16'h1021);
    else if (shift)  crc <= {crc[14:0], 1'b0};
  end

  assign dout = crc[15];
endmodule

module sd_card_responder #(
  parameter int DATA_WIDTH = 4,
  parameter int BLK_SIZE   = 64,
  parameter int BLK_CNT_W  = 16,
  parameter int GAP_CYCLES = 10
) (
  input logic CLK,
  input logic RESET,
  sd_card_responder_if.slave bus
);
  localparam int PAY_CYC = BLK_SIZE * 8 / DATA_WIDTH;
  localparam int SUBS    = 8 / DATA_WIDTH;
  localparam int MAX_A   = (PAY_CYC > 16) ? PAY_CYC : 16;
  localparam int MAXC    = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAY_CYC - 1);
  localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(15);

  // ---------------- CMD channel ----------------
  logic [135:0] resp_sr;
  logic [7:0]   resp_cnt;
  logic         resp_busy, resp_done;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      resp_sr   <= '0;
      resp_cnt  <= '0;
      resp_busy <= 1'b0;
      resp_done <= 1'b0;
    end else begin
      resp_done <= 1'b0;
      if (!resp_busy) begin
        if (bus.resp_start) begin
          resp_busy <= 1'b1;
          // Short responses are left-aligned so the MSB always sits at bit 135
          resp_sr   <= bus.resp_long ? bus.resp_data : {bus.resp_data[47:0], 88'd0};
          resp_cnt  <= bus.resp_long ? 8'd135 : 8'd47;
        end
      end else begin
        resp_sr  <= {resp_sr[134:0], 1'b0};
        resp_cnt <= resp_cnt - 8'd1;
        if (resp_cnt == 8'd0) begin
          resp_busy <= 1'b0;
          resp_done <= 1'b1;
        end
      end
    end
  end

  assign bus.cmd_to_host = resp_busy ? resp_sr[135] : 1'b1;
  assign bus.resp_busy   = resp_busy;
  assign bus.resp_done   = resp_done;

  // ---------------- DAT channel ----------------
  typedef enum logic [2:0] {S_IDLE, S_GAP, S_START, S_PAYLOAD, S_CRC, S_END} dstate_t;
  dstate_t state, nxt;

  logic [CNT_W-1:0]      cnt;
  logic [BLK_CNT_W-1:0]  blk_cnt_q, blocks_sent, bs_next;
  logic                  inc_q, abort_q, done_q, finish;
  logic [7:0]            blk_base, byte_val, sr, nb;
  logic [2:0]            sub;
  logic [DATA_WIDTH-1:0] crc_msb;
  logic [DATA_WIDTH-1:0] dat;

  assign bs_next = blocks_sent + BLK_CNT_W'(1);
  assign nb      = byte_val + {7'd0, inc_q};
  assign finish  = abort_q || bus.data_abort || ((blk_cnt_q != '0) && (bs_next == blk_cnt_q));

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:    if (bus.data_start) nxt = (GAP_CYCLES == 0) ? S_START : S_GAP;
      S_GAP:     if (cnt == '0) nxt = S_START;
      S_START:   nxt = S_PAYLOAD;
      S_PAYLOAD: if (cnt == '0) nxt = S_CRC;
      S_CRC:     if (cnt == '0) nxt = S_END;
      S_END:     nxt = finish ? S_IDLE : ((GAP_CYCLES == 0) ? S_START : S_GAP);
      default:   nxt = S_IDLE;
    endcase
  end

  always_comb begin
    dat = '1;
    unique case (state)
      S_START:   dat = '0;
      S_PAYLOAD: dat = sr[7 -: DATA_WIDTH];
      S_CRC:     dat = crc_msb;
      default:   dat = '1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt <= '0; blk_cnt_q <= '0; inc_q <= 1'b0; blk_base <= '0; byte_val <= '0;
      sr <= '0; sub <= '0; blocks_sent <= '0; abort_q <= 1'b0; done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state != S_IDLE && bus.data_abort) abort_q <= 1'b1;
      // Each timed state loads its length on entry and counts down to zero
      if (nxt != state) begin
        unique case (nxt)
          S_GAP:     cnt <= GAP_LAST;
          S_PAYLOAD: cnt <= PAY_LAST;
          S_CRC:     cnt <= CRC_LAST;
          default:   cnt <= '0;
        endcase
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      unique case (state)
        S_IDLE: if (bus.data_start) begin
          blk_cnt_q   <= bus.blk_cnt;
          inc_q       <= bus.pattern_inc;
          blk_base    <= bus.pattern_seed;
          blocks_sent <= '0;
          abort_q     <= 1'b0;
        end
        S_START: begin
          byte_val <= blk_base;
          sr       <= blk_base;
          sub      <= '0;
        end
        S_PAYLOAD: begin
          if (sub == 3'(SUBS - 1)) begin
            byte_val <= nb;
            sr       <= nb;
            sub      <= '0;
          end else begin
            sr  <= sr << DATA_WIDTH;
            sub <= sub + 3'd1;
          end
        end
        S_END: begin
          blocks_sent <= bs_next;
          blk_base    <= blk_base + {7'd0, inc_q};
          if (finish) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Line l carries bit (8-DATA_WIDTH+l) of each shifted chunk; the top line gets the byte MSB
  for (genvar l = 0; l < DATA_WIDTH; l++) begin : g_lane
    sd_crc16_lane u_crc (
      .clk  (CLK),
      .rst  (RESET),
      .clr  (state == S_START),
      .upd  (state == S_PAYLOAD),
      .shift(state == S_CRC),
      .din  (sr[8-DATA_WIDTH+l]),
      .dout (crc_msb[l])
    );
  end

  assign bus.dat_to_host = dat;
  assign bus.data_busy   = (state != S_IDLE);
  assign bus.data_done   = done_q;
  assign bus.blocks_sent = blocks_sent;
endmodule
